// File: rtl/viterbi_pkg.sv
// Shared types and trellis helpers for the rate-1/2, K=3 Viterbi decoder.
// The state is the last two message bits; the newest bit is in s[1].
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam int TAIL_LEN   = K - 1;

    typedef logic [1:0] state_t;

    typedef enum logic [1:0] {
        FILL,
        TRACE,
        OUTPUT
    } fsm_t;

    // An ACS label picks which of the two possible predecessors survived.
    function automatic state_t prev_state(state_t s, logic d);
        return {s[0], d};
    endfunction

    function automatic logic state_bit(state_t s);
        return s[1];
    endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Decision-vector input stream and decoded-bit output stream of the traceback unit.
interface viterbi_traceback_if #(
    parameter int NUM_STATES = 4
) ();

    logic                  dec_valid;
    logic                  dec_ready;
    logic [NUM_STATES-1:0] dec_bits;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_bit;
    logic                  out_last;

    modport slave (
        input  dec_valid, dec_bits, out_ready,
        output dec_ready, out_valid, out_bit, out_last
    );

    modport master (
        output dec_valid, dec_bits, out_ready,
        input  dec_ready, out_valid, out_bit, out_last
    );

endinterface

// File: rtl/viterbi_dec_ram.sv
// Frame buffer of ACS decision vectors: synchronous write, asynchronous read.
module viterbi_dec_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/viterbi_traceback.sv
// Survivor-path traceback: buffers one zero-terminated frame of ACS decisions,
// traces back from state 0, then streams the message bits out in forward order.
module viterbi_traceback #(
    parameter int FRAME_LEN  = 16,
    parameter int TAIL_LEN   = viterbi_pkg::TAIL_LEN,
    parameter int NUM_STATES = viterbi_pkg::NUM_STATES
) (
    input  logic               clock,
    input  logic               reset,
    viterbi_traceback_if.slave io,
    output logic               busy
);
    import viterbi_pkg::*;

    localparam int               PTR_W    = $clog2(FRAME_LEN);
    localparam logic [PTR_W-1:0] LAST_IN  = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] LAST_OUT = PTR_W'(FRAME_LEN - TAIL_LEN - 1);

    fsm_t                  state_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W-1:0]      out_ptr_q;
    logic [PTR_W-1:0]      out_ptr_d;
    state_t                tb_state_q;
    logic                  dec_ready_q;
    logic                  out_valid_q;
    logic                  out_bit_q;
    logic                  out_last_q;
    logic                  busy_q;
    logic [FRAME_LEN-1:0]  bmem_q;
    logic [NUM_STATES-1:0] dmem_rd;
    logic                  dec_accept;

    // dec_ready_q is only ever high in FILL, so it alone gates the write.
    assign dec_accept = io.dec_valid && dec_ready_q;
    assign out_ptr_d  = out_ptr_q + 1'b1;

    viterbi_dec_ram #(
        .DEPTH  (FRAME_LEN),
        .WIDTH  (NUM_STATES),
        .ADDR_W (PTR_W)
    ) u_dec_ram (
        .clock   (clock),
        .we_i    (dec_accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (io.dec_bits),
        .raddr_i (rd_ptr_q),
        .rdata_o (dmem_rd)
    );

    always_ff @(posedge clock) begin
        if (state_q == TRACE) bmem_q[rd_ptr_q] <= state_bit(tb_state_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_ptr_q   <= '0;
            tb_state_q  <= '0;
            dec_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (dec_accept) begin
                        if (wr_ptr_q == LAST_IN) begin
                            wr_ptr_q    <= '0;
                            state_q     <= TRACE;
                            tb_state_q  <= '0;
                            rd_ptr_q    <= LAST_IN;
                            dec_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                TRACE: begin
                    tb_state_q <= prev_state(tb_state_q, dmem_rd[tb_state_q]);
                    if (rd_ptr_q == '0) begin
                        // bmem[0] is written on this same edge, so take bit 0 straight from the trace.
                        state_q     <= OUTPUT;
                        out_ptr_q   <= '0;
                        out_valid_q <= 1'b1;
                        out_bit_q   <= state_bit(tb_state_q);
                        out_last_q  <= (LAST_OUT == '0);
                    end else begin
                        rd_ptr_q <= rd_ptr_q - 1'b1;
                    end
                end
                OUTPUT: begin
                    if (io.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= FILL;
                            wr_ptr_q    <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            dec_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            out_ptr_q  <= out_ptr_d;
                            out_bit_q  <= bmem_q[out_ptr_d];
                            out_last_q <= (out_ptr_d == LAST_OUT);
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign io.dec_ready = dec_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_bit   = out_bit_q;
    assign io.out_last  = out_last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback: a FRAME_LEN=6 and a FRAME_LEN=16 instance, driven one at a time,
// against frames built forward from random message bits along a known trellis path.
module tb_viterbi_traceback;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       sel  = 1'b0;
    logic       dv   = 1'b0;
    logic [3:0] db   = 4'd0;
    logic       ordy = 1'b0;
    logic       busy_a, busy_b;

    viterbi_traceback_if #(.NUM_STATES(4)) ifa ();
    viterbi_traceback_if #(.NUM_STATES(4)) ifb ();

    assign ifa.dec_valid = dv & ~sel;
    assign ifa.dec_bits  = db;
    assign ifa.out_ready = ordy & ~sel;
    assign ifb.dec_valid = dv & sel;
    assign ifb.dec_bits  = db;
    assign ifb.out_ready = ordy & sel;

    viterbi_traceback #(.FRAME_LEN(6), .TAIL_LEN(2), .NUM_STATES(4)) dut_a (
        .clock (clock), .reset (reset), .io (ifa), .busy (busy_a)
    );
    viterbi_traceback #(.FRAME_LEN(16), .TAIL_LEN(2), .NUM_STATES(4)) dut_b (
        .clock (clock), .reset (reset), .io (ifb), .busy (busy_b)
    );

    logic obs_dec_ready, obs_out_valid, obs_out_bit, obs_out_last, obs_busy;
    assign obs_dec_ready = sel ? ifb.dec_ready : ifa.dec_ready;
    assign obs_out_valid = sel ? ifb.out_valid : ifa.out_valid;
    assign obs_out_bit   = sel ? ifb.out_bit   : ifa.out_bit;
    assign obs_out_last  = sel ? ifb.out_last  : ifa.out_last;
    assign obs_busy      = sel ? busy_b        : busy_a;

    int         total = 0;
    int         bad   = 0;
    int         flen  = 6;
    int         nmsg  = 4;
    logic [3:0] frame_d [256];
    logic       exp_u   [256];
    logic [6:0] pat     = 7'b1101001;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // kind 0: random message; 1: known path (FRAME_LEN=6 only); 2: all-zero
    task automatic make_frame(input int kind);
        logic [1:0] s, ns;
        logic       u;
        logic [3:0] d;
        logic [3:0] kd [6];
        flen = sel ? 16 : 6;
        nmsg = flen - 2;
        kd = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0001};
        s = 2'd0;
        for (int t = 0; t < flen; t++) begin
            if (kind == 1) begin
                frame_d[t] = kd[t];
                exp_u[t]   = (t == 0 || t == 2 || t == 3);
            end else if (kind == 2) begin
                frame_d[t] = 4'd0;
                exp_u[t]   = 1'b0;
            end else begin
                // Walk the trellis forward and plant the surviving label; others are noise.
                u = (t < nmsg) ? 1'($urandom_range(1, 0)) : 1'b0;
                ns = {u, s[1]};
                d = 4'($urandom);
                d[ns] = s[0];
                frame_d[t] = d;
                exp_u[t]   = u;
                s = ns;
            end
        end
    endtask

    task automatic feed_frame(input int gap_pct);
        int   idx = 0;
        int   n   = 0;
        logic rs;
        while (idx < flen && n < flen * 10 + 20) begin
            rs = obs_dec_ready;
            if ($urandom_range(99, 0) < gap_pct) dv = 1'b0;
            else begin
                dv = 1'b1;
                db = frame_d[idx];
            end
            @(negedge clock);
            if (dv && rs) idx++;
            n++;
        end
        check("feed_done", idx, flen);
    endtask

    // Entered on the first falling edge after the final accept (k=1).
    task automatic recv_frame(input int rdy_mode, input bit junk);
        int   nbits = 0, first_k = 0, rdy_low = 0, klast = 0, pidx = 0;
        logic pv = 1'b0, pb = 1'b0, pl = 1'b0, phs = 1'b0, hs;
        for (int k = 1; k <= flen + nmsg * 20 + 50; k++) begin
            dv = junk;
            if (junk) db = 4'($urandom);
            if (!obs_dec_ready) rdy_low++;
            if (obs_out_valid && first_k == 0) first_k = k;
            if (rdy_mode < 0) ordy = obs_out_valid ? pat[pidx % 7] : 1'b0;
            else ordy = ($urandom_range(99, 0) < rdy_mode);
            if (obs_out_valid) pidx++;
            if (pv && !phs) begin
                check("hold_vld", int'(obs_out_valid), 1);
                check("hold_bit", int'(obs_out_bit), int'(pb));
                check("hold_last", int'(obs_out_last), int'(pl));
            end
            hs = obs_out_valid && ordy;
            if (hs) begin
                check("bit", int'(obs_out_bit), int'(exp_u[nbits]));
                check("last", int'(obs_out_last), int'(nbits == nmsg - 1));
                nbits++;
                klast = k;
            end
            pv = obs_out_valid; pb = obs_out_bit; pl = obs_out_last; phs = hs;
            @(negedge clock);
            if (nbits == nmsg) break;
        end
        check("nbits", nbits, nmsg);
        check("latency", first_k, flen + 1);
        check("rdy_low", rdy_low, klast);
        check("vld_drop", int'(obs_out_valid), 0);
        check("rdy_back", int'(obs_dec_ready), 1);
        check("busy_end", int'(obs_busy), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_rdy_a", int'(ifa.dec_ready), 1);
        check("rst_vld_a", int'(ifa.out_valid), 0);
        check("rst_bit_a", int'(ifa.out_bit), 0);
        check("rst_last_a", int'(ifa.out_last), 0);
        check("rst_busy_a", int'(busy_a), 0);
        check("rst_rdy_b", int'(ifb.dec_ready), 1);
        check("rst_busy_b", int'(busy_b), 0);
        reset = 1'b0;
        @(negedge clock);

        // Known path, full throughput, then with the fixed stall pattern.
        sel = 1'b0;
        make_frame(1); feed_frame(0); recv_frame(100, 1'b0);
        make_frame(1); feed_frame(0); recv_frame(-1, 1'b0);

        // Back-to-back known frames streamed continuously.
        make_frame(1); feed_frame(0); recv_frame(100, 1'b0);
        make_frame(1); feed_frame(0); recv_frame(100, 1'b0);

        // Upstream keeps pushing junk while busy; the next frame must start cleanly.
        make_frame(0); feed_frame(0); recv_frame(100, 1'b1);
        make_frame(0); feed_frame(0); recv_frame(60, 1'b1);
        make_frame(0); feed_frame(0); recv_frame(100, 1'b0);

        // Reset in the middle of TRACE.
        make_frame(0); feed_frame(0);
        dv = 1'b0;
        repeat (2) @(negedge clock);
        check("busy_in_trace", int'(obs_busy), 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_rdy", int'(obs_dec_ready), 1);
        check("mid_rst_busy", int'(obs_busy), 0);
        check("mid_rst_vld", int'(obs_out_valid), 0);
        reset = 1'b0;
        @(negedge clock);
        make_frame(1); feed_frame(0); recv_frame(100, 1'b0);

        // Long-frame instance: all-zero, then random frames with gaps and backpressure.
        sel = 1'b1;
        make_frame(2); feed_frame(0); recv_frame(100, 1'b0);
        for (int f = 0; f < 6; f++) begin
            make_frame(0); feed_frame(30); recv_frame(50, f[0]);
        end

        sel = 1'b0;
        for (int f = 0; f < 10; f++) begin
            make_frame(0); feed_frame(25); recv_frame(70, f[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
